multdiv_sequencer: RTL and testbench
====================================

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-003 SHALL have port: clk  in  1  rising-edge clock.
REQ-004 SHALL have port: reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have port: start  in  1  decoder issues MULTU/DIVU this cycle.
REQ-006 SHALL have port: opdiv  in  1  0 = MULTU, 1 = DIVU; sampled with start.
REQ-007 SHALL have port: srca  in  WIDTH  rs operand; sampled with start.
REQ-008 SHALL have port: srcb  in  WIDTH  rt operand; sampled with start.
REQ-009 SHALL have port: mfreq  in  1  decoder has MFHI/MFLO in the current cycle.
REQ-010 SHALL have port: busy  out  1  iteration in progress.
REQ-011 SHALL have port: stall  out  1  freeze PC/fetch this cycle.
REQ-012 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: hi  out  WIDTH  architectural HI register.
REQ-014 SHALL have port: lo  out  WIDTH  architectural LO register.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN when start=1.
- RUN->DONE after WIDTH iterations.
- DONE->RUN when start=1, otherwise DONE->IDLE.
REQ-016 SHALL load operands and op on the edge accepting start, and set the iteration counter to WIDTH.
REQ-017 SHALL perform exactly one iteration per RUN cycle and decrement the counter by 1.
REQ-018 SHALL implement MULTU as unsigned shift-add, forming a 2*WIDTH product: hi = upper half, lo = lower half.
REQ-019 SHALL implement DIVU as unsigned restoring division: lo = quotient, hi = remainder.
REQ-020 SHALL set lo = all ones and hi = srca when DIVU has srcb = 0; latency is unchanged.
REQ-021 SHALL write hi/lo only on the edge entering DONE, and hold them at all other times, including throughout RUN.
REQ-022 SHALL assert done only in the DONE state; done is high in the WIDTH+1-th cycle after the start cycle, and hi/lo are valid in that same cycle.
REQ-023 SHALL assert busy iff the state is RUN.
REQ-024 SHALL drive stall = mfreq & busy, combinationally.
REQ-025 SHALL ignore start while in RUN; operands and counter are not disturbed.
REQ-026 SHALL accept a start in DONE (back-to-back operations); done is still pulsed for the finished operation.
REQ-027 SHALL give mfreq no effect on the state or the registers.

Reset
REQ-028 SHALL, on reset low, immediately force: state IDLE; hi = 0; lo = 0; counter = 0; working registers = 0; busy = 0; done = 0; stall = 0.
REQ-029 SHALL abort an operation interrupted by reset mid-RUN without a done pulse; hi/lo remain 0 after reset.
REQ-030 SHALL make the first start after reset release behave identically to a start from IDLE.

Configuration
REQ-031 SHALL use the macro MULTDIV_DIVU_EN.
- Defined: opdiv selects DIVU per REQ-019/020.
- Undefined: opdiv is ignored, every operation is MULTU, and no divider logic is synthesized.

Structure
REQ-032 SHALL place in shared package multdiv_pkg:
- the state enum (IDLE, RUN, DONE);
- the MULTU funct code 6'b011001;
- the DIVU funct code 6'b011011;
- the MFHI funct code 6'b010000;
- the MFLO funct code 6'b010010.
REQ-033 SHALL put one combinational iteration step (add-or-pass for MULTU, subtract-and-restore for DIVU) in the sub-module multdiv_step; the FSM, counter and hi/lo registers stay in multdiv_sequencer.

Verification
REQ-034 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> done in cycle 33 after start, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 SHALL cover (MULTDIV_DIVU_EN defined): DIVU 100/7 -> lo=14, hi=2; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5; both with 33-cycle latency.
REQ-036 SHALL cover: mfreq=1 during RUN -> stall=1 every RUN cycle; mfreq=1 in DONE -> stall=0 with new hi/lo visible.
REQ-037 SHALL cover: second start at RUN cycle 10 -> ignored, result equals the first operation's, exactly one done pulse.
REQ-038 SHALL cover: reset asserted at RUN cycle 20 -> busy=0, hi=lo=0, no done pulse; a following MULTU 3*4 -> lo=12, hi=0.
REQ-039 SHALL cover: start in the DONE cycle of 6*7 followed by 2*2 -> first done lo=42, second done 33 cycles later with lo=4.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the MULTU/DIVU sequencer: FSM states and the
// decoder funct codes that drive it.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration: shift-add for MULTU, restoring subtract for DIVU.
// The DIVU path exists only when MULTDIV_DIVU_EN is defined.
module multdiv_step
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             opdiv,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH:0] sum;

`ifdef MULTDIV_DIVU_EN
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   // With b = 0 every trial subtract succeeds: q fills with ones and acc
   // ends up holding the dividend, which is exactly the divide-by-zero result.
   always_comb begin
      sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
      shifted = {acc, q[WIDTH-1]};
      diff    = shifted[WIDTH-1:0] - b;
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
      if (opdiv) begin
         if (shifted >= {1'b0, b}) begin
            acc_nxt = diff;
            q_nxt   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = shifted[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], 1'b0};
         end
      end
   end
`else
   logic unused_opdiv;
   assign unused_opdiv = opdiv;

   always_comb begin
      sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
   end
`endif

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative MULTU/DIVU unit with HI/LO registers and fetch stall on MFHI/MFLO.
// DIVU support is enabled by defining MULTDIV_DIVU_EN; otherwise all ops are MULTU.
module multdiv_sequencer
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             opdiv,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             mfreq,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] acc_q, q_q, b_q, hi_q, lo_q;
   logic [WIDTH-1:0] acc_nxt, q_nxt;
   logic             load, last;

`ifdef MULTDIV_DIVU_EN
   logic op_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q <= 1'b0;
      end else if (load) begin
         op_q <= opdiv;
      end
   end
`else
   logic op_q, unused_opdiv;
   assign op_q         = 1'b0;
   assign unused_opdiv = opdiv;
`endif

   multdiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .opdiv   (op_q),
      .acc     (acc_q),
      .q       (q_q),
      .b       (b_q),
      .acc_nxt (acc_nxt),
      .q_nxt   (q_nxt)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q == CntW'(1)) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            load    = start;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            cnt_q <= CntW'(WIDTH);
            acc_q <= '0;
            q_q   <= srca;
            b_q   <= srcb;
         end else if (state_q == RUN) begin
            cnt_q <= cnt_q - CntW'(1);
            acc_q <= acc_nxt;
            q_q   <= q_nxt;
            // HI/LO change only on the edge into DONE.
            if (last) begin
               hi_q <= acc_nxt;
               lo_q <= q_nxt;
            end
         end
      end
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign stall = mfreq & busy;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer; DIVU vectors run only with MULTDIV_DIVU_EN.
module tb_multdiv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        opdiv;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        mfreq;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors = 0;
   int miscompares = 0;

   multdiv_sequencer #(
      .WIDTH (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .opdiv (opdiv),
      .srca  (srca),
      .srcb  (srcb),
      .mfreq (mfreq),
      .busy  (busy),
      .stall (stall),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues an op at the current negedge and follows it to its DONE cycle (cycle 33).
   task automatic do_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic mf, input int restart_at,
                        input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int ndone = 0;
      int nbusy_bad = 0;
      int nstall_bad = 0;
      int nheld_bad = 0;
      start = 1'b1;
      opdiv = op;
      srca  = a;
      srcb  = b;
      mfreq = mf;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (k < 33) begin
            if (done !== 1'b0) ndone++;
            if (busy !== 1'b1) nbusy_bad++;
            if (stall !== mf) nstall_bad++;
            if (hi !== prev_hi || lo !== prev_lo) nheld_bad++;
         end
         if (k == 1) begin
            start = 1'b0;
            srca  = 32'hDEAD_BEEF;
            srcb  = 32'h0BAD_F00D;
         end
         if (restart_at > 0 && k == restart_at) begin
            start = 1'b1;
            opdiv = 1'b0;
            srca  = 32'd9;
            srcb  = 32'd9;
         end
         if (restart_at > 0 && k == restart_at + 1) start = 1'b0;
      end
      chk({tag, " run_done_count"}, 64'(ndone), 64'd0);
      chk({tag, " run_busy_bad"}, 64'(nbusy_bad), 64'd0);
      chk({tag, " run_stall_bad"}, 64'(nstall_bad), 64'd0);
      chk({tag, " run_hilo_held_bad"}, 64'(nheld_bad), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd1);
      chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
      chk({tag, " stall_at_done"}, 64'(stall), 64'd0);
      chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
      chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
      mfreq = 1'b0;
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      chk({tag, " idle_done"}, 64'(done), 64'd0);
      chk({tag, " idle_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int ndone;
      reset = 1'b0;
      start = 1'b0;
      opdiv = 1'b0;
      srca  = '0;
      srcb  = '0;
      mfreq = 1'b1;

      @(negedge clk);
      @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset stall", 64'(stall), 64'd0);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      reset = 1'b1;
      mfreq = 1'b0;
      @(negedge clk);

      // mfreq held high across RUN and into DONE
      do_op("mul_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0,
            32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001);
      idle_chk("mul_ff");

      // second start during RUN cycle 10 must be ignored
      do_op("mul_restart", 1'b0, 32'h1234_5678, 32'h0000_0010, 1'b0, 10,
            32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 32'h2345_6780);
      idle_chk("mul_restart");

      // back-to-back: 2*2 issued in the DONE cycle of 6*7
      do_op("mul_6x7", 1'b0, 32'd6, 32'd7, 1'b0, 0,
            32'h0000_0001, 32'h2345_6780, 32'd0, 32'd42);
      do_op("mul_2x2", 1'b0, 32'd2, 32'd2, 1'b0, 0,
            32'd0, 32'd42, 32'd0, 32'd4);
      idle_chk("mul_2x2");

`ifdef MULTDIV_DIVU_EN
      do_op("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0, 0,
            32'd0, 32'd4, 32'd2, 32'd14);
      idle_chk("div_100_7");
      do_op("div_5_0", 1'b1, 32'd5, 32'd0, 1'b0, 0,
            32'd2, 32'd14, 32'd5, 32'hFFFF_FFFF);
      idle_chk("div_5_0");
`endif

      // reset during RUN cycle 20
      start = 1'b1;
      opdiv = 1'b0;
      srca  = 32'h0000_FFFF;
      srcb  = 32'h0000_FFFF;
      mfreq = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      reset = 1'b0;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort stall", 64'(stall), 64'd0);
      chk("abort hi", 64'(hi), 64'd0);
      chk("abort lo", 64'(lo), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      mfreq = 1'b0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done !== 1'b0) ndone++;
      end
      chk("abort no_done", 64'(ndone), 64'd0);

      do_op("mul_3x4", 1'b0, 32'd3, 32'd4, 1'b0, 0,
            32'd0, 32'd0, 32'd0, 32'd12);
      idle_chk("mul_3x4");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
